// File: rtl/clk_seq.sv
// Clock/reset sequencer: synchronises the external reset pin, holds the core
// in reset for a fixed interval after power-up or a soft reset request, and
// applies clock register writes to the clock generator, inserting a settle
// wait whenever an oscillator or PLL enable is newly switched on.
module clk_seq #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       res,
  input  logic       inp_resn,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_req,
  output logic [6:0] cfg_out,
  output logic       nres,
  output logic       busy
);

  localparam logic [23:0] RST_LOAD    = 24'(RST_CYCLES);
  localparam logic [23:0] SETTLE_LOAD = 24'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    POR    = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2,
    SRESET = 2'd3
  } state_t;

  state_t      state_reg;
  logic [1:0]  sync_reg;
  logic        ext_ok;
  logic [23:0] cnt_reg;
  logic [6:0]  cfg_reg;
  logic [2:0]  sel_reg;
  logic        nres_reg;
  logic        busy_reg;
  logic        expired;
  logic        new_enable;

  // Only the second synchroniser stage is trusted as a clean level.
  assign ext_ok = sync_reg[1];

  // The shared counter runs out on the edge where it holds 1, so an interval
  // loaded on edge N ends exactly on edge N + load value.
  assign expired = (cnt_reg == 24'd1);

  // A write that turns on an oscillator or PLL not already running needs the
  // settle wait before the new clock source may be selected.
  assign new_enable = |(cfg_req[6:5] & ~cfg_reg[6:5]);

  assign cfg_out = cfg_reg;
  assign nres    = nres_reg;
  assign busy    = busy_reg;

  // Two-flop synchroniser for the asynchronous external reset pin.
  always_ff @(posedge clk) begin
    if (res) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], inp_resn};
    end
  end

  // Sequencer FSM: reset, external reset, timer expiry and writes, in that priority.
  always_ff @(posedge clk) begin
    if (res) begin
      state_reg <= POR;
      cnt_reg   <= RST_LOAD;
      cfg_reg   <= 7'h00;
      sel_reg   <= 3'b000;
      nres_reg  <= 1'b0;
      busy_reg  <= 1'b1;
    end else if (!ext_ok) begin
      // External reset wins over any settle or soft reset in progress and
      // keeps the counter parked at the full hold length.
      state_reg <= POR;
      cnt_reg   <= RST_LOAD;
      cfg_reg   <= 7'h00;
      nres_reg  <= 1'b0;
      busy_reg  <= 1'b1;
    end else begin
      case (state_reg)
        POR, SRESET: begin
          if (expired) begin
            state_reg <= RUN;
            nres_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 24'd1;
          end
        end
        SETTLE: begin
          if (expired) begin
            state_reg    <= RUN;
            cfg_reg[2:0] <= sel_reg;
            busy_reg     <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 24'd1;
          end
        end
        RUN: begin
          if (cfg_wr) begin
            if (cfg_req[7]) begin
              // Soft reset: the rest of the requested word is discarded.
              state_reg <= SRESET;
              cnt_reg   <= RST_LOAD;
              cfg_reg   <= 7'h00;
              nres_reg  <= 1'b0;
              busy_reg  <= 1'b1;
            end else if (new_enable) begin
              // Enables and mode go out now; the clock select is held back
              // until the new source has had time to settle.
              state_reg    <= SETTLE;
              cnt_reg      <= SETTLE_LOAD;
              cfg_reg[6:3] <= cfg_req[6:3];
              sel_reg      <= cfg_req[2:0];
              busy_reg     <= 1'b1;
            end else begin
              cfg_reg <= cfg_req[6:0];
            end
          end
        end
        default: begin
          state_reg <= POR;
          cnt_reg   <= RST_LOAD;
          cfg_reg   <= 7'h00;
          nres_reg  <= 1'b0;
          busy_reg  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_seq.sv
// Self-checking bench for clk_seq: directed scenarios followed by random
// traffic, every edge compared against a deadline-based reference model.
module tb_clk_seq;

  localparam int RST = 16;
  localparam int SET = 8;

  localparam int M_POR  = 0;
  localparam int M_RUN  = 1;
  localparam int M_SET  = 2;
  localparam int M_SRST = 3;

  logic       clk;
  logic       res;
  logic       inp_resn;
  logic       cfg_wr;
  logic [7:0] cfg_req;
  logic [6:0] cfg_out;
  logic       nres;
  logic       busy;

  int errors;
  int checks;
  int edge_n;

  // Reference model state: a mode, an absolute edge deadline and the
  // applied configuration.
  int         m_mode;
  int         m_deadline;
  logic       m_s1;
  logic       m_ext;
  logic [6:0] m_cfg;
  logic [2:0] m_sel;

  clk_seq #(
    .RST_CYCLES   (RST),
    .SETTLE_CYCLES(SET)
  ) dut (
    .clk     (clk),
    .res     (res),
    .inp_resn(inp_resn),
    .cfg_wr  (cfg_wr),
    .cfg_req (cfg_req),
    .cfg_out (cfg_out),
    .nres    (nres),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic r, input logic ir, input logic w,
                            input logic [7:0] q);
    logic seen;
    if (r) begin
      m_mode     = M_POR;
      m_cfg      = 7'h00;
      m_s1       = 1'b0;
      m_ext      = 1'b0;
      m_deadline = edge_n + RST;
    end else begin
      seen  = m_ext;
      m_ext = m_s1;
      m_s1  = ir;
      if (!seen) begin
        // Held in reset: the reset interval restarts on every such edge.
        m_mode     = M_POR;
        m_cfg      = 7'h00;
        m_deadline = edge_n + RST;
      end else if (m_mode != M_RUN) begin
        if (edge_n == m_deadline) begin
          if (m_mode == M_SET) m_cfg[2:0] = m_sel;
          m_mode = M_RUN;
        end
      end else if (w) begin
        if (q[7]) begin
          m_mode     = M_SRST;
          m_cfg      = 7'h00;
          m_deadline = edge_n + RST;
        end else if ((q[6] && !m_cfg[6]) || (q[5] && !m_cfg[5])) begin
          m_mode      = M_SET;
          m_cfg[6:3]  = q[6:3];
          m_sel       = q[2:0];
          m_deadline  = edge_n + SET;
        end else begin
          m_cfg = q[6:0];
        end
      end
    end
  endtask

  task automatic check_all();
    logic exp_nres;
    logic exp_busy;
    exp_nres = (m_mode == M_RUN) || (m_mode == M_SET);
    exp_busy = (m_mode != M_RUN);
    checks++;
    assert (cfg_out === m_cfg) else begin
      errors++;
      $error("FAIL cfg_out edge=%0d observed=%h expected=%h", edge_n, cfg_out, m_cfg);
    end
    checks++;
    assert (nres === exp_nres) else begin
      errors++;
      $error("FAIL nres edge=%0d observed=%b expected=%b", edge_n, nres, exp_nres);
    end
    checks++;
    assert (busy === exp_busy) else begin
      errors++;
      $error("FAIL busy edge=%0d observed=%b expected=%b", edge_n, busy, exp_busy);
    end
  endtask

  // One clock edge: drive inputs, advance the model, sample outputs 1 ns later.
  task automatic step(input logic r, input logic ir, input logic w,
                      input logic [7:0] q);
    res      = r;
    inp_resn = ir;
    cfg_wr   = w;
    cfg_req  = q;
    @(posedge clk);
    edge_n++;
    model_edge(r, ir, w, q);
    #1;
    check_all();
    $display("edge=%0d res=%b inp_resn=%b wr=%b req=%h -> cfg_out=%h nres=%b busy=%b",
             edge_n, r, ir, w, q, cfg_out, nres, busy);
  endtask

  initial begin
    int rose_at;
    int busy_cnt;
    int low_cnt;
    logic [7:0] q;
    logic r;
    logic ir;
    logic w;
    errors = 0;
    checks = 0;
    edge_n = 0;
    m_mode = M_POR;
    m_deadline = 0;
    m_s1 = 1'b0;
    m_ext = 1'b0;
    m_cfg = 7'h00;
    m_sel = 3'b000;

    // Reset state.
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);

    // Power-up timing: nres rises on the 18th edge after the pin is sampled.
    rose_at = 0;
    for (int k = 1; k <= 24; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      if (nres === 1'b1 && rose_at == 0) rose_at = k;
    end
    checks++;
    assert (rose_at === 18) else begin
      errors++;
      $error("FAIL por_timing observed=%0d expected=%0d", rose_at, 18);
    end

    // Fast switch: applied on the next edge, never busy.
    step(1'b0, 1'b1, 1'b1, 8'h01);
    checks++;
    assert (cfg_out === 7'h01) else begin
      errors++;
      $error("FAIL fast_switch observed=%h expected=%h", cfg_out, 7'h01);
    end
    step(1'b0, 1'b1, 1'b1, 8'h00);

    // PLL enable with a stray write mid-settle.
    busy_cnt = 0;
    step(1'b0, 1'b1, 1'b1, 8'h6F);
    checks++;
    assert (cfg_out === 7'h68) else begin
      errors++;
      $error("FAIL pll_first observed=%h expected=%h", cfg_out, 7'h68);
    end
    if (busy === 1'b1) busy_cnt++;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b1, (k == 2), 8'h05);
      if (busy === 1'b1) busy_cnt++;
    end
    checks++;
    assert (busy_cnt === SET) else begin
      errors++;
      $error("FAIL settle_len observed=%0d expected=%0d", busy_cnt, SET);
    end
    checks++;
    assert (cfg_out === 7'h6F) else begin
      errors++;
      $error("FAIL pll_final observed=%h expected=%h", cfg_out, 7'h6F);
    end

    // Soft reset.
    low_cnt = 0;
    step(1'b0, 1'b1, 1'b1, 8'h80);
    if (nres === 1'b0) low_cnt++;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      if (nres === 1'b0) low_cnt++;
    end
    checks++;
    assert (low_cnt === RST) else begin
      errors++;
      $error("FAIL soft_reset_len observed=%0d expected=%0d", low_cnt, RST);
    end

    // External reset during settle aborts it.
    step(1'b0, 1'b1, 1'b1, 8'h6F);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    assert (nres === 1'b0 && cfg_out === 7'h00) else begin
      errors++;
      $error("FAIL abort observed=%b/%h expected=0/00", nres, cfg_out);
    end
    for (int k = 0; k < 22; k++) step(1'b0, 1'b1, 1'b0, 8'h00);

    // Reset outranks a simultaneous soft reset write.
    step(1'b0, 1'b1, 1'b1, 8'h03);
    step(1'b1, 1'b1, 1'b1, 8'h80);
    checks++;
    assert (nres === 1'b0 && busy === 1'b1 && cfg_out === 7'h00) else begin
      errors++;
      $error("FAIL priority observed=%b%b/%h expected=01/00", nres, busy, cfg_out);
    end
    for (int k = 0; k < 22; k++) step(1'b0, 1'b1, 1'b0, 8'h00);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      q = 8'($urandom);
      if ($urandom_range(0, 7) != 0) q[7] = 1'b0;
      w  = ($urandom_range(0, 3) == 0);
      ir = ($urandom_range(0, 63) != 0);
      r  = ($urandom_range(0, 199) == 0);
      step(r, ir, w, q);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
